// File: rtl/checkout_scan_controller.sv
// Checkout lane scan sequencer: captures a UPC/mark on each scan edge, evaluates
// the discount and stolen rules, keeps saturating tallies and locks out scans.
module checkout_scan_controller #(
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scan_req,
  input  logic [2:0]         upc,
  input  logic               mark,
  input  logic               alarm_clr,
  output logic               scan_ack,
  output logic               discount,
  output logic               stolen,
  output logic               alarm,
  output logic               busy,
  output logic [COUNT_W-1:0] item_count,
  output logic [COUNT_W-1:0] discount_count,
  output logic [COUNT_W-1:0] theft_count
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHOW  = 2'd2,
    ALARM = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        upc_q;
  logic              mark_q;
  logic              scan_prev;
  logic [HOLD_W-1:0] hold;

  logic scan_edge_c;
  logic disc_c;
  logic stole_c;

  assign scan_edge_c = scan_req & ~scan_prev;
  assign disc_c      = upc_q[1] | (upc_q[2] & upc_q[0]);
  assign stole_c     = (~upc_q[1] & ~upc_q[0] & ~mark_q) | (upc_q[2] & upc_q[0] & ~mark_q);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

  // Next-state decode; edges outside IDLE are simply never looked at.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (scan_edge_c) state_nxt = EVAL;
      EVAL:    state_nxt = stole_c ? ALARM : SHOW;
      SHOW:    if (hold == HOLD_W'(1)) state_nxt = IDLE;
      ALARM:   if (alarm_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture, result latching, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_prev      <= 1'b1;
      upc_q          <= 3'd0;
      mark_q         <= 1'b0;
      hold           <= '0;
      scan_ack       <= 1'b0;
      discount       <= 1'b0;
      stolen         <= 1'b0;
      alarm          <= 1'b0;
      busy           <= 1'b0;
      item_count     <= '0;
      discount_count <= '0;
      theft_count    <= '0;
    end else begin
      scan_prev <= scan_req;
      busy      <= (state_nxt != IDLE);
      scan_ack  <= (state == EVAL);
      unique case (state)
        IDLE: begin
          if (scan_edge_c) begin
            upc_q  <= upc;
            mark_q <= mark;
          end
        end
        EVAL: begin
          discount   <= disc_c;
          stolen     <= stole_c;
          item_count <= sat_inc(item_count);
          if (disc_c)  discount_count <= sat_inc(discount_count);
          if (stole_c) theft_count    <= sat_inc(theft_count);
          if (stole_c) alarm <= 1'b1;
          else         hold  <= HOLD_W'(HOLD_CYCLES);
        end
        SHOW: begin
          hold <= hold - HOLD_W'(1);
        end
        ALARM: begin
          if (alarm_clr) alarm <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_checkout_scan_controller.sv
// Directed bench for checkout_scan_controller: reset behaviour, clean/theft
// scans, lockout, full rule sweep and counter saturation on a narrow instance.
module tb_checkout_scan_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reset_n2;
  logic       scan_req;
  logic [2:0] upc;
  logic       mark;
  logic       alarm_clr;

  logic       scan_ack, discount, stolen, alarm, busy;
  logic [7:0] item_count, discount_count, theft_count;

  logic       scan_ack2, discount2, stolen2, alarm2, busy2;
  logic [1:0] item_count2, discount_count2, theft_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  checkout_scan_controller #(.COUNT_W(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .scan_req(scan_req), .upc(upc), .mark(mark),
    .alarm_clr(alarm_clr), .scan_ack(scan_ack), .discount(discount), .stolen(stolen),
    .alarm(alarm), .busy(busy), .item_count(item_count),
    .discount_count(discount_count), .theft_count(theft_count)
  );

  checkout_scan_controller #(.COUNT_W(2), .HOLD_CYCLES(4)) dut2 (
    .clk(clk), .reset_n(reset_n2), .scan_req(scan_req), .upc(upc), .mark(mark),
    .alarm_clr(alarm_clr), .scan_ack(scan_ack2), .discount(discount2), .stolen(stolen2),
    .alarm(alarm2), .busy(busy2), .item_count(item_count2),
    .discount_count(discount_count2), .theft_count(theft_count2)
  );

  typedef struct {
    logic [2:0] upc;
    logic       mark;
    logic       exp_disc;
    logic       exp_stole;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Edge sampled at the first clock, evaluated at the second; results visible on return.
  task automatic do_scan(input logic [2:0] u, input logic m);
    upc      = u;
    mark     = m;
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy | busy2) && n < 20) begin
      step();
      n++;
    end
    if (busy | busy2) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=busy expected=idle within 20 cycles");
    end
  endtask

  initial begin
    int busy_n, ack_n;
    logic alarm_seen;
    int exp_dc, exp_tc;

    // Rule table worked out by hand: disc = U1|(U2&U0); stole = ~mark&((~U1&~U0)|(U2&U0))
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd2, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3'd3, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'd3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3'd4, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{3'd4, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd5, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{3'd5, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{3'd6, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'd6, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{3'd7, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{3'd7, 1'b1, 1'b1, 1'b0};

    reset_n   = 1'b0;
    reset_n2  = 1'b0;
    scan_req  = 1'b1;
    upc       = 3'd0;
    mark      = 1'b0;
    alarm_clr = 1'b0;

    // 1: reset with scan_req high, release, no spurious scan
    step();
    step();
    check("rst_outputs", {scan_ack, discount, stolen, alarm, busy}, 5'b0);
    check("rst_counters", {item_count, discount_count, theft_count}, 24'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rel_no_ack", {scan_ack, busy}, 2'b00);
    end
    check("rel_item_count", item_count, 8'd0);
    scan_req = 1'b0;
    step();
    do_scan(3'd2, 1'b1);
    check("t1_item_count", item_count, 8'd1);
    wait_idle();

    // 2: clean discount scan, busy window and single ack
    reset_dut();
    upc = 3'd2; mark = 1'b1; scan_req = 1'b1;
    busy_n = 0; ack_n = 0; alarm_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) scan_req = 1'b0;
      if (busy) busy_n++;
      if (scan_ack) ack_n++;
      alarm_seen = alarm_seen | alarm;
    end
    check("t2_busy_cycles", busy_n, 5);
    check("t2_ack_pulses", ack_n, 1);
    check("t2_alarm", alarm_seen, 1'b0);
    check("t2_results", {discount, stolen}, 2'b10);
    check("t2_counts", {item_count, discount_count, theft_count}, {8'd1, 8'd1, 8'd0});

    // 3: theft, lockout during ALARM, attendant clear
    reset_dut();
    do_scan(3'd0, 1'b0);
    check("t3_results", {discount, stolen, alarm, busy}, 4'b0111);
    check("t3_theft", theft_count, 8'd1);
    for (int i = 0; i < 2; i++) begin
      scan_req = 1'b1; step();
      scan_req = 1'b0; step();
    end
    check("t3_locked_items", item_count, 8'd1);
    check("t3_alarm_held", alarm, 1'b1);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    check("t3_cleared", {alarm, busy}, 2'b00);
    check("t3_stolen_persist", stolen, 1'b1);

    // 4: discount and theft together; clear beats simultaneous edge
    reset_dut();
    do_scan(3'd5, 1'b0);
    check("t4_results", {discount, stolen, alarm}, 3'b111);
    check("t4_counts", {discount_count, theft_count}, {8'd1, 8'd1});
    alarm_clr = 1'b1;
    scan_req  = 1'b1;
    step();
    alarm_clr = 1'b0;
    check("t4_clear_wins", {alarm, busy}, 2'b00);
    step();
    step();
    check("t4_level_no_edge", {busy, item_count}, {1'b0, 8'd1});
    scan_req = 1'b0;
    step();

    // 5: full {upc,mark} sweep
    reset_dut();
    exp_dc = 0;
    exp_tc = 0;
    for (int i = 0; i < 16; i++) begin
      do_scan(vecs[i].upc, vecs[i].mark);
      check($sformatf("sweep_%0d_disc", i), discount, vecs[i].exp_disc);
      check($sformatf("sweep_%0d_stole", i), {stolen, alarm}, {vecs[i].exp_stole, vecs[i].exp_stole});
      if (vecs[i].exp_disc) exp_dc++;
      if (vecs[i].exp_stole) exp_tc++;
      if (alarm) begin
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
      end
      wait_idle();
    end
    check("sweep_items", item_count, 8'd16);
    check("sweep_disc_count", discount_count, 8'(exp_dc));
    check("sweep_theft_count", theft_count, 8'(exp_tc));

    // 6: narrow counters saturate, then reset lands mid-SHOW
    reset_n2 = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      do_scan(3'd2, 1'b1);
      wait_idle();
    end
    check("sat_items", item_count2, 2'd3);
    check("sat_disc", discount_count2, 2'd3);
    check("sat_theft", theft_count2, 2'd0);
    do_scan(3'd2, 1'b1);
    step();
    check("mid_show_busy", busy2, 1'b1);
    reset_n2 = 1'b0;
    #1;
    check("mid_rst_counters", {item_count2, discount_count2, theft_count2}, 6'd0);
    check("mid_rst_status", {busy2, scan_ack2, discount2, alarm2}, 4'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
